// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bus bundle between two requesters, the arbiter and the shared memory
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          m0_req;
   logic          m0_we;
   logic [AW-1:0] m0_adr;
   logic [DW-1:0] m0_wd;
   logic          m0_gnt;
   logic [DW-1:0] m0_rd;

   logic          m1_req;
   logic          m1_we;
   logic [AW-1:0] m1_adr;
   logic [DW-1:0] m1_wd;
   logic          m1_gnt;
   logic [DW-1:0] m1_rd;

   logic          mem_we;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   // arbiter side
   modport slave (
      input  m0_req, m0_we, m0_adr, m0_wd,
      input  m1_req, m1_we, m1_adr, m1_wd,
      input  mem_rd,
      output m0_gnt, m0_rd, m1_gnt, m1_rd,
      output mem_we, mem_adr, mem_wd
   );

   // requesters plus memory, as seen from outside the arbiter
   modport master (
      output m0_req, m0_we, m0_adr, m0_wd,
      output m1_req, m1_we, m1_adr, m1_wd,
      output mem_rd,
      input  m0_gnt, m0_rd, m1_gnt, m1_rd,
      input  mem_we, mem_adr, mem_wd
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter with bounded hold for a single-port memory
module mem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_HOLD = 16
) (
   input logic         clk,
   input logic         reset,
   mem_arbiter_if.slave bus
);
   localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic          last, last_nxt;
   logic [CW-1:0] hold_cnt, hold_nxt;
   logic          gnt0, gnt1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         last     <= 1'b1;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      hold_nxt  = hold_cnt;
      case (state)
         IDLE: begin
            if (bus.m0_req && bus.m1_req) state_nxt = last ? GNT0 : GNT1;
            else if (bus.m0_req)          state_nxt = GNT0;
            else if (bus.m1_req)          state_nxt = GNT1;
         end
         GNT0: begin
            // a released grant hands straight over without an idle bubble
            if (!bus.m0_req)                                state_nxt = bus.m1_req ? GNT1 : IDLE;
            else if (bus.m1_req && hold_cnt == HOLD_LAST)   state_nxt = GNT1;
         end
         GNT1: begin
            if (!bus.m1_req)                                state_nxt = bus.m0_req ? GNT0 : IDLE;
            else if (bus.m0_req && hold_cnt == HOLD_LAST)   state_nxt = GNT0;
         end
         default: state_nxt = IDLE;
      endcase

      if (state_nxt != state) begin
         hold_nxt = '0;
         if (state_nxt == GNT0)      last_nxt = 1'b0;
         else if (state_nxt == GNT1) last_nxt = 1'b1;
      end else if (state != IDLE && hold_cnt != HOLD_LAST) begin
         hold_nxt = hold_cnt + 1'b1;
      end
   end

   // outputs decode the state register only, so reset clears them without a clock edge
   assign gnt0 = (state == GNT0);
   assign gnt1 = (state == GNT1);

   always_comb begin
      bus.m0_gnt  = gnt0;
      bus.m1_gnt  = gnt1;
      bus.mem_we  = (gnt0 & bus.m0_req & bus.m0_we) | (gnt1 & bus.m1_req & bus.m1_we);
      bus.mem_adr = gnt0 ? bus.m0_adr : (gnt1 ? bus.m1_adr : {AW{1'b0}});
      bus.mem_wd  = gnt0 ? bus.m0_wd  : (gnt1 ? bus.m1_wd  : {DW{1'b0}});
      bus.m0_rd   = gnt0 ? bus.mem_rd : {DW{1'b0}};
      bus.m1_rd   = gnt1 ? bus.mem_rd : {DW{1'b0}};
   end
endmodule
